// File: rtl/axil_sram_slave.sv
// -----------------------------------------------------------------------------
// axil_sram_slave
// AXI-Lite responder modelling the word-addressed instruction/data SRAM seen by
// the fetch unit and LSU. Read (AR/R) and write (AW/W/B) each run on their own
// FSM with one outstanding transaction and a parameterised response latency.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   araddr/arvalid/arready   read address channel
//   rdata/rresp/rvalid/rready read data channel (rresp 2'b11 = DECERR)
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel (byte strobes)
//   bresp/bvalid/bready      write response channel
//
// Optional build macro: AXIL_SRAM_RAND_DELAY_EN
//   Adds a 16-bit LFSR whose low 3 bits extend each latency by 0..7 cycles.
// -----------------------------------------------------------------------------
module axil_sram_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                RD_LAT     = 2,
  parameter int                WR_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int MEM_WORDS = 1 << DEPTH_LOG2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_LAT  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_LAT  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [4:0] RD_LAT_C = 5'(RD_LAT);
  localparam logic [4:0] WR_LAT_C = 5'(WR_LAT);

  // Address lies inside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS).
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    addr_in_range = (a >= BASE_ADDR) &&
                    (((a - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == {ADDR_W{1'b0}});
  endfunction

  // Word index; addr[1:0] drops out in the shift.
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    word_idx = DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic [1:0]        r_rstate;
  logic [4:0]        r_rcnt;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_arready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic [1:0]        r_wstate;
  logic [4:0]        r_wcnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_wacc;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  logic [2:0]        w_rd_extra;
  logic [2:0]        w_wr_extra;
  logic              w_wr_commit;
  logic              w_w_in_range;
  logic [DEPTH_LOG2-1:0] w_w_idx;

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_rd_extra = r_lfsr[2:0];
  assign w_wr_extra = r_lfsr[2:0];
`else
  assign w_rd_extra = 3'd0;
  assign w_wr_extra = 3'd0;
`endif

  assign w_wr_commit  = (r_wstate == W_LAT) && (r_wcnt == 5'd0);
  assign w_w_in_range = addr_in_range(r_waddr);
  assign w_w_idx      = word_idx(r_waddr);

  // Read FSM: accept AR, wait out the latency, present and hold R until rready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= 5'd0;
      r_raddr   <= {ADDR_W{1'b0}};
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= {DATA_W{1'b0}};
      r_rresp   <= 2'b00;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && r_arready) begin
            r_raddr   <= araddr;
            r_rcnt    <= RD_LAT_C + {2'b00, w_rd_extra};
            r_arready <= 1'b0;
            r_rstate  <= R_LAT;
          end else begin
            // arready rises one cycle after reset release
            r_arready <= 1'b1;
          end
        end
        R_LAT: begin
          if (r_rcnt != 5'd0) begin
            r_rcnt <= r_rcnt - 5'd1;
          end else begin
            // Sampled with a non-blocking read: a same-cycle write is not seen.
            if (addr_in_range(r_raddr)) begin
              r_rdata <= r_mem[word_idx(r_raddr)];
              r_rresp <= 2'b00;
            end else begin
              r_rdata <= {DATA_W{1'b0}};
              r_rresp <= 2'b11;
            end
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b0;
        end
      endcase
    end
  end

  // Write FSM: one-cycle AW/W ready pulse once both valids are seen, latency,
  // then commit and hold B until bready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= 5'd0;
      r_waddr  <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_wstrb  <= 4'd0;
      r_wacc   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_wacc) begin
            r_wacc <= 1'b0;
            if (awvalid && wvalid) begin
              r_waddr  <= awaddr;
              r_wdata  <= wdata;
              r_wstrb  <= wstrb;
              r_wcnt   <= WR_LAT_C + {2'b00, w_wr_extra};
              r_wstate <= W_LAT;
            end
          end else begin
            r_wacc <= awvalid && wvalid;
          end
        end
        W_LAT: begin
          if (r_wcnt != 5'd0) begin
            r_wcnt <= r_wcnt - 5'd1;
          end else begin
            r_bresp  <= w_w_in_range ? 2'b00 : 2'b11;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
          r_wacc   <= 1'b0;
          r_bvalid <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: byte-strobed write at commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit && w_w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  assign arready = r_arready;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rvalid  = r_rvalid;
  assign awready = r_wacc;
  assign wready  = r_wacc;
  assign bresp   = r_bresp;
  assign bvalid  = r_bvalid;

endmodule

// File: tb/tb_axil_sram_slave.sv
module tb_axil_sram_slave;

  localparam int     RD_LAT = 2;
  localparam int     WR_LAT = 2;
  localparam longint BASE   = 64'h8000_0000;
  localparam longint SPAN   = 64'd4 * 64'd4096;

  logic        clk;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  axil_sram_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for handshake (cycle %0d)", nm, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [int];

  function automatic bit inr(input logic [31:0] a);
    longint x;
    x = a;
    return (x >= BASE) && (x < BASE + SPAN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    longint x;
    x = a;
    return int'((x - BASE) / 4);
  endfunction

  bit          e_ar, e_aw, e_rv, e_bv, e_rknown;
  logic [31:0] e_rdata;
  logic [1:0]  e_rresp, e_bresp;
  bit          rd_pend, wr_pend;
  longint      rd_due, wr_due, nxt;
  logic [31:0] rd_addr, wr_addr, wr_data, old;
  logic [3:0]  wr_strb;

  // Timestamp model: outputs are derived from handshake cycle + latency and
  // from a plain word array; checked every cycle at the falling edge.
  initial begin
    e_ar = 0; e_aw = 0; e_rv = 0; e_bv = 0; e_rknown = 0;
    rd_pend = 0; wr_pend = 0; rd_due = 0; wr_due = 0;
    e_rdata = 32'd0; e_rresp = 2'd0; e_bresp = 2'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_ar = 0; e_aw = 0; e_rv = 0; e_bv = 0; rd_pend = 0; wr_pend = 0;
      end
      chk("m_arready", {31'd0, arready}, {31'd0, e_ar});
      chk("m_awready", {31'd0, awready}, {31'd0, e_aw});
      chk("m_wready",  {31'd0, wready},  {31'd0, e_aw});
      chk("m_rvalid",  {31'd0, rvalid},  {31'd0, e_rv});
      chk("m_bvalid",  {31'd0, bvalid},  {31'd0, e_bv});
      if (e_rv) begin
        if (e_rknown) chk("m_rdata", rdata, e_rdata);
        chk("m_rresp", {30'd0, rresp}, {30'd0, e_rresp});
      end
      if (e_bv) chk("m_bresp", {30'd0, bresp}, {30'd0, e_bresp});
      if (reset) begin
        nxt = cyc + 1;
        if (rd_pend) begin
          if (e_rv && rready) rd_pend = 0;
        end else if (e_ar && arvalid) begin
          rd_pend = 1; rd_due = nxt + 1 + RD_LAT; rd_addr = araddr;
        end
        if (rd_pend && nxt == rd_due) begin
          if (inr(rd_addr)) begin
            e_rresp = 2'b00;
            e_rknown = mdl.exists(widx(rd_addr));
            if (e_rknown) e_rdata = mdl[widx(rd_addr)];
          end else begin
            e_rresp = 2'b11; e_rdata = 32'd0; e_rknown = 1;
          end
        end
        e_rv = rd_pend && (nxt >= rd_due);
        e_ar = !rd_pend;

        if (wr_pend) begin
          if (e_bv && bready) wr_pend = 0;
          e_aw = 0;
        end else if (e_aw) begin
          if (awvalid && wvalid) begin
            wr_pend = 1; wr_due = nxt + 1 + WR_LAT;
            wr_addr = awaddr; wr_data = wdata; wr_strb = wstrb;
          end
          e_aw = 0;
        end else begin
          e_aw = awvalid && wvalid;
        end
        if (wr_pend && nxt == wr_due) begin
          e_bresp = inr(wr_addr) ? 2'b00 : 2'b11;
          if (inr(wr_addr)) begin
            if (wr_strb == 4'hF) begin
              mdl[widx(wr_addr)] = wr_data;
            end else if (mdl.exists(widx(wr_addr))) begin
              old = mdl[widx(wr_addr)];
              for (int b = 0; b < 4; b++)
                if (wr_strb[b]) old[8*b +: 8] = wr_data[8*b +: 8];
              mdl[widx(wr_addr)] = old;
            end
          end
        end
        e_bv = wr_pend && (nxt >= wr_due);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [1:0] resp);
    bit ok;
    longint t;
    lat = -1; resp = 2'bxx;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (awready) ok = 1;
    end
    if (!ok) tmo("aw_handshake");
    @(posedge clk); #1;
    t = cyc; awvalid = 1'b0; wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; lat = int'(cyc - t); resp = bresp; end
    end
    if (!ok) tmo("b_wait");
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    bit ok;
    longint t;
    lat = -1; resp = 2'bxx; d = 32'hxxxx_xxxx;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (arready) ok = 1;
    end
    if (!ok) tmo("ar_handshake");
    @(posedge clk); #1;
    t = cyc; arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; lat = int'(cyc - t); d = rdata; resp = rresp; end
    end
    if (!ok) tmo("r_wait");
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, bs;
  int          lat, pulses, first;
  bit          ok, bseen;
  longint      t0;

  initial begin
    reset = 1'b0; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);

    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, lat, bs);
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, bs);
    chk("wr_latency", lat, 32'd3);
    chk("wr_bresp", {30'd0, bs}, 32'd0);
    do_read(32'h8000_0010, rd, rs, lat);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_rresp", {30'd0, rs}, 32'd0);

    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, lat, bs);
    do_read(32'h8000_0010, rd, rs, lat);
    chk("partial_wr", rd, 32'hDE22_BE44);
    do_read(32'h8000_0013, rd, rs, lat);
    chk("unaligned_rd", rd, 32'hDE22_BE44);

    do_read(32'h7FFF_FFFC, rd, rs, lat);
    chk("oor_rd_resp", {30'd0, rs}, 32'd3);
    chk("oor_rd_data", rd, 32'd0);
    do_write(32'h8000_4000, 32'h1234_5678, 4'hF, lat, bs);
    chk("oor_wr_resp", {30'd0, bs}, 32'd3);
    do_read(32'h8000_0000, rd, rs, lat);
    chk("word0_kept", rd, 32'hCAFE_F00D);

    // Back-pressure on R with a competing arvalid.
    @(posedge clk); #1;
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (arready) ok = 1; end
    if (!ok) tmo("bp_ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (rvalid) ok = 1; end
    if (!ok) tmo("bp_r");
    @(posedge clk); #1;
    araddr = 32'h8000_0000; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
      chk("bp_rdata", rdata, 32'hDE22_BE44);
      chk("bp_arready", {31'd0, arready}, 32'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1; arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_rvalid", {31'd0, rvalid}, 32'd0);
    chk("bp_done_arready", {31'd0, arready}, 32'd1);

    // Lone awvalid, then wvalid: a single ready pulse.
    @(posedge clk); #1;
    awaddr = 32'h8000_0020; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    repeat (4) begin @(negedge clk); chk("lone_aw", {31'd0, awready}, 32'd0); end
    @(posedge clk); #1;
    wvalid = 1'b1; t0 = cyc; pulses = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (awready) begin pulses++; if (first < 0) first = int'(cyc - t0); end
      @(posedge clk); #1;
      if (pulses > 0) begin awvalid = 1'b0; wvalid = 1'b0; end
    end
    chk("aw_pulses", pulses, 32'd1);
    chk("aw_pulse_at", first, 32'd1);
    do_read(32'h8000_0020, rd, rs, lat);
    chk("lone_aw_data", rd, 32'h0BAD_F00D);

    // Read and write commit to the same word in the same cycle.
    @(posedge clk); #1;
    awaddr = 32'h8000_0010; wdata = 32'h5566_7788; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; rd = rdata; end
    end
    if (!ok) tmo("same_cycle_r");
    chk("same_cycle_old", rd, 32'hDE22_BE44);
    repeat (2) @(posedge clk);
    do_read(32'h8000_0010, rd, rs, lat);
    chk("same_cycle_new", rd, 32'h5566_7788);

    // Reset during W_LAT drops the write.
    @(posedge clk); #1;
    awaddr = 32'h8000_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (awready) ok = 1; end
    if (!ok) tmo("rst_aw");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bseen = 0;
    repeat (3) begin @(negedge clk); if (bvalid) bseen = 1; end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (bvalid) bseen = 1; end
    chk("rst_no_bvalid", {31'd0, bseen}, 32'd0);
    do_read(32'h8000_0020, rd, rs, lat);
    chk("rst_word_kept", rd, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
